rf_ex_hazard_ctrl: RTL and testbench
====================================

Name: rf_ex_hazard_ctrl

Overview:
- Write-side controller for the RF/EX pipeline register; decides every cycle what enters EX: the decoded instruction, or a bubble.
- Tracks in-flight destination registers in a 2-deep scoreboard (EX, MEM).
- Generates load-use stalls, taken-branch flushes, registered operand-forwarding selects for EX, and the flag-forward select for conditional branches.

Parameters:
- REG_W, 5, register specifier width.
- ZR_IDX, 31, index of XZR; never a hazard source or target.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- Rn_rf  in  REG_W  first source specifier of the instruction in RF.
- Rm_rf  in  REG_W  second source specifier (Rm or Rd for STUR) in RF.
- uses_rn_rf  in  1  RF instruction reads Rn.
- uses_rm_rf  in  1  RF instruction reads Rm.
- Rd_rf  in  REG_W  destination specifier in RF.
- RegWrite_rf  in  1  RF instruction writes Rd.
- MemToReg_rf  in  2  writeback source; MTR_MEM marks a load.
- UpdateFlags_rf  in  1  RF instruction sets NZCV.
- reads_flags_rf  in  1  RF instruction is B.cond.
- BrTaken_ex  in  1  branch resolved taken in EX this cycle.
- stall_pc  out  1  hold PC.
- stall_ifrf  out  1  hold IF/RF register.
- flush_ifrf  out  1  load NOP into IF/RF register.
- bubble_ex  out  1  force all RF/EX control fields (RegWrite, MemWrite, UpdateFlags, BrTaken) to 0.
- fwd_a_sel  out  2  registered; EX operand A source.
- fwd_b_sel  out  2  registered; EX operand B source.
- flag_fwd  out  1  combinational; B.cond in RF takes ALU flags from EX, not the flag register.

Behaviour:
- Scoreboard entry fields: valid, rd, is_load, sets_flags.
- Scoreboard update every rising edge:
  - ex_e <= bubble_ex ? invalid : {RegWrite_rf && Rd_rf!=ZR_IDX, Rd_rf, MemToReg_rf==MTR_MEM, UpdateFlags_rf}.
  - mem_e <= ex_e.
  - sets_flags is kept even when valid=0.
- Register file is write-through, so no WB forwarding exists.
- Match definitions:
  - hitA(e) = e.valid && uses_rn_rf && Rn_rf==e.rd && Rn_rf!=ZR_IDX.
  - hitB(e) is the same using Rm.
- load_use = hitA(ex_e)||hitB(ex_e), restricted to ex_e.is_load.
- Combinational outputs:
  - flush = BrTaken_ex.
  - flush_ifrf = flush.
  - stall_pc = stall_ifrf = load_use && !flush.
  - bubble_ex = flush || load_use.
  - flag_fwd = reads_flags_rf && ex_e.sets_flags && !bubble_ex.
- Forward selects are registered at the clock edge where the RF instruction enters EX; if bubble_ex, they load FWD_RF.
  - fwd_a_sel <= hitA(ex_e) ? FWD_EXMEM : hitA(mem_e) ? FWD_MEMWB : FWD_RF.
  - fwd_b_sel follows the same rule using hitB.
  - The nearer stage wins.
- Load-use costs exactly 1 stall cycle. The following cycle the load is in mem_e, so the consumer gets FWD_MEMWB.
- Flush and load_use together: flush wins, no stall; the wrong-path instruction is discarded.
- Reset:
  - All entries go invalid and fwd selects go to FWD_RF.
  - Combinational outputs follow from the cleared state: all 0 unless BrTaken_ex=1.
  - Reset mid-stall ends the stall in the next cycle.
- A single-cycle BrTaken_ex pulse produces exactly one flush cycle.

Decomposition:
- Shared package core_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - MTR_ALU=2'b00, MTR_MEM=2'b01.
  - ZR_IDX.
  - Typedef sb_entry_t {valid, rd, is_load, sets_flags}.
- One sub-module, hazard_cmp: combinational specifier comparator producing hitA/hitB for one entry. It is instantiated twice, once for ex_e and once for mem_e.

Test Plan:
- ADD X1,X2,X3 then SUB X4,X1,X5 -> no stall; fwd_a_sel=01 while SUB is in EX.
- ADD X1 then NOP then ORR X6,X7,X1 -> fwd_b_sel=10.
- Same pattern with X31 as the destination -> sel=00.
- LDUR X9,[X10] then ADD X11,X9,X9 -> exactly one cycle of stall_pc=stall_ifrf=bubble_ex=1; next cycle fwd_a_sel=fwd_b_sel=10.
- ADDS X1,X2,X3 then B.EQ in RF -> flag_fwd=1, no stall.
- Same sequence with a bubble ahead of the B.EQ -> flag_fwd=0.
- BrTaken_ex=1 concurrent with a load-use condition -> flush_ifrf=1, bubble_ex=1, stall_pc=0; one cycle later ex_e is invalid.
- Assert reset during a load-use stall -> next cycle all outputs 0 and fwd selects 00; pipeline resumes without the stall.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline constants and the hazard scoreboard entry type.
package core_pkg;

    localparam int CORE_REG_W = 5;
    localparam int ZR_IDX     = 31;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic [CORE_REG_W-1:0] rd;
        logic                  is_load;
        logic                  sets_flags;
    } sb_entry_t;

endpackage

// File: rtl/hazard_cmp.sv
// Compares the RF instruction's source specifiers against one in-flight
// destination; XZR never matches.
module hazard_cmp #(
    parameter int REG_W  = 5,
    parameter int ZR_IDX = 31
) (
    input  logic             e_valid_i,
    input  logic [REG_W-1:0] e_rd_i,
    input  logic [REG_W-1:0] rn_i,
    input  logic [REG_W-1:0] rm_i,
    input  logic             uses_rn_i,
    input  logic             uses_rm_i,
    output logic             hit_a_o,
    output logic             hit_b_o
);

    assign hit_a_o = e_valid_i && uses_rn_i && (rn_i == e_rd_i) && (rn_i != REG_W'(ZR_IDX));
    assign hit_b_o = e_valid_i && uses_rm_i && (rm_i == e_rd_i) && (rm_i != REG_W'(ZR_IDX));

endmodule

// File: rtl/rf_ex_hazard_ctrl.sv
// RF/EX write-side hazard control: 2-deep destination scoreboard (EX, MEM),
// load-use stall, branch flush, registered forward selects and flag forward.
module rf_ex_hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int ZR_IDX = core_pkg::ZR_IDX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rn_rf,
    input  logic [REG_W-1:0] Rm_rf,
    input  logic             uses_rn_rf,
    input  logic             uses_rm_rf,
    input  logic [REG_W-1:0] Rd_rf,
    input  logic             RegWrite_rf,
    input  logic [1:0]       MemToReg_rf,
    input  logic             UpdateFlags_rf,
    input  logic             reads_flags_rf,
    input  logic             BrTaken_ex,
    output logic             stall_pc,
    output logic             stall_ifrf,
    output logic             flush_ifrf,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             flag_fwd
);

    import core_pkg::sb_entry_t;
    import core_pkg::FWD_RF;
    import core_pkg::FWD_EXMEM;
    import core_pkg::FWD_MEMWB;
    import core_pkg::MTR_MEM;

    // sb_q[0] is the instruction now in EX, sb_q[1] the one now in MEM.
    sb_entry_t  sb_q [2];
    sb_entry_t  ex_d;
    logic [1:0] hit_a;
    logic [1:0] hit_b;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       flush;
    logic       load_use;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp
            hazard_cmp #(
                .REG_W  (REG_W),
                .ZR_IDX (ZR_IDX)
            ) u_cmp (
                .e_valid_i (sb_q[gi].valid),
                .e_rd_i    (sb_q[gi].rd),
                .rn_i      (Rn_rf),
                .rm_i      (Rm_rf),
                .uses_rn_i (uses_rn_rf),
                .uses_rm_i (uses_rm_rf),
                .hit_a_o   (hit_a[gi]),
                .hit_b_o   (hit_b[gi])
            );
        end
    endgenerate

    assign flush      = BrTaken_ex;
    assign load_use   = sb_q[0].is_load && (hit_a[0] || hit_b[0]);
    assign flush_ifrf = flush;
    assign stall_pc   = load_use && !flush;
    assign stall_ifrf = load_use && !flush;
    assign bubble_ex  = flush || load_use;
    // sets_flags is tracked independently of valid (e.g. flag-setting ops writing XZR).
    assign flag_fwd   = reads_flags_rf && sb_q[0].sets_flags && !bubble_ex;
    assign fwd_a_sel  = fwd_a_q;
    assign fwd_b_sel  = fwd_b_q;

    always_comb begin
        ex_d = '0;
        if (!bubble_ex) begin
            ex_d.valid      = RegWrite_rf && (Rd_rf != REG_W'(ZR_IDX));
            ex_d.rd         = Rd_rf;
            ex_d.is_load    = (MemToReg_rf == MTR_MEM);
            ex_d.sets_flags = UpdateFlags_rf;
        end
    end

    // The nearer producer (EX) takes priority over the older one (MEM).
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!bubble_ex) begin
            if (hit_a[0])      fwd_a_d = FWD_EXMEM;
            else if (hit_a[1]) fwd_a_d = FWD_MEMWB;
            if (hit_b[0])      fwd_b_d = FWD_EXMEM;
            else if (hit_b[1]) fwd_b_d = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q[0] <= '0;
            sb_q[1] <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            sb_q[0] <= ex_d;
            sb_q[1] <= sb_q[0];
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    logic unused_mem_fields;
    assign unused_mem_fields = ^{sb_q[1].is_load, sb_q[1].sets_flags};

endmodule

// File: tb/tb_rf_ex_hazard_ctrl.sv
// Random and directed stimulus against a distance-based producer model of the hazard controller.
module tb_rf_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rn_rf, Rm_rf, Rd_rf;
    logic       uses_rn_rf, uses_rm_rf, RegWrite_rf, UpdateFlags_rf, reads_flags_rf, BrTaken_ex;
    logic [1:0] MemToReg_rf;
    logic       stall_pc, stall_ifrf, flush_ifrf, bubble_ex, flag_fwd;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    rf_ex_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .Rn_rf(Rn_rf), .Rm_rf(Rm_rf), .uses_rn_rf(uses_rn_rf), .uses_rm_rf(uses_rm_rf),
        .Rd_rf(Rd_rf), .RegWrite_rf(RegWrite_rf), .MemToReg_rf(MemToReg_rf),
        .UpdateFlags_rf(UpdateFlags_rf), .reads_flags_rf(reads_flags_rf), .BrTaken_ex(BrTaken_ex),
        .stall_pc(stall_pc), .stall_ifrf(stall_ifrf), .flush_ifrf(flush_ifrf), .bubble_ex(bubble_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .flag_fwd(flag_fwd)
    );

    // Model: history of what entered EX; index 0 = one instruction ahead (EX), 1 = two ahead (MEM).
    bit       h_wr   [2];
    bit [4:0] h_rd   [2];
    bit       h_load [2];
    bit       h_flag [2];
    bit [1:0] exp_fwd_a = 0, exp_fwd_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Distance (1 or 2) to the nearest older instruction writing reg r, 0 if none.
    function automatic int producer_dist(input bit [4:0] r, input bit used);
        if (!used || r == 5'd31) return 0;
        for (int k = 0; k < 2; k++)
            if (h_wr[k] && h_rd[k] == r) return k + 1;
        return 0;
    endfunction

    function automatic bit [1:0] sel_of(input int d);
        return (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
    endfunction

    function automatic bit m_load_use();
        return h_load[0] && (producer_dist(Rn_rf, uses_rn_rf) == 1 || producer_dist(Rm_rf, uses_rm_rf) == 1);
    endfunction

    always @(posedge clk) begin
        bit bub;
        bub = BrTaken_ex || m_load_use();
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                h_wr[k] = 0; h_rd[k] = 0; h_load[k] = 0; h_flag[k] = 0;
            end
            exp_fwd_a = 0; exp_fwd_b = 0;
            check_en  = 1;
        end else begin
            exp_fwd_a = bub ? 2'b00 : sel_of(producer_dist(Rn_rf, uses_rn_rf));
            exp_fwd_b = bub ? 2'b00 : sel_of(producer_dist(Rm_rf, uses_rm_rf));
            h_wr[1] = h_wr[0]; h_rd[1] = h_rd[0]; h_load[1] = h_load[0]; h_flag[1] = h_flag[0];
            h_wr[0]   = !bub && RegWrite_rf && Rd_rf != 5'd31;
            h_rd[0]   = bub ? 5'd0 : Rd_rf;
            h_load[0] = !bub && MemToReg_rf == 2'b01;
            h_flag[0] = !bub && UpdateFlags_rf;
        end
    end

    // Compare process: every cycle, between edges, once a reset edge has established state.
    always @(negedge clk) begin
        bit lu, bub;
        #2;
        if (check_en) begin
            lu  = m_load_use();
            bub = BrTaken_ex || lu;
            chk("flush_ifrf", flush_ifrf, BrTaken_ex);
            chk("stall_pc",   stall_pc,   lu && !BrTaken_ex);
            chk("stall_ifrf", stall_ifrf, lu && !BrTaken_ex);
            chk("bubble_ex",  bubble_ex,  bub);
            chk("flag_fwd",   flag_fwd,   reads_flags_rf && h_flag[0] && !bub);
            chk("fwd_a_sel",  fwd_a_sel,  exp_fwd_a);
            chk("fwd_b_sel",  fwd_b_sel,  exp_fwd_b);
        end
    end

    task automatic drive(input bit [4:0] rn, input bit urn, input bit [4:0] rm, input bit urm,
                         input bit [4:0] rd, input bit rw, input bit [1:0] mtr,
                         input bit uf, input bit rf, input bit br);
        @(negedge clk);
        Rn_rf = rn; uses_rn_rf = urn; Rm_rf = rm; uses_rm_rf = urm;
        Rd_rf = rd; RegWrite_rf = rw; MemToReg_rf = mtr;
        UpdateFlags_rf = uf; reads_flags_rf = rf; BrTaken_ex = br;
        #3;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 31, 0, 0, 0, 0, 0);
    endtask

    function automatic bit [4:0] pick_reg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v + 1);
    endfunction

    initial begin
        reset = 1;
        Rn_rf = 0; Rm_rf = 0; Rd_rf = 31; uses_rn_rf = 0; uses_rm_rf = 0;
        RegWrite_rf = 0; MemToReg_rf = 0; UpdateFlags_rf = 0; reads_flags_rf = 0; BrTaken_ex = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        #3;
        chk("reset_stall", stall_pc, 0);
        chk("reset_bubble", bubble_ex, 0);
        chk("reset_fwd_a", fwd_a_sel, 0);
        chk("reset_fwd_b", fwd_b_sel, 0);

        // ADD X1,X2,X3 ; SUB X4,X1,X5
        drive(2, 1, 3, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 5, 1, 4, 1, 0, 0, 0, 0);
        chk("add_sub_stall", stall_pc, 0);
        nop();
        chk("add_sub_fwd_a", fwd_a_sel, 1);
        nop();

        // ADD X1 ; NOP ; ORR X6,X7,X1
        drive(2, 1, 3, 1, 1, 1, 0, 0, 0, 0);
        nop();
        drive(7, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        nop();
        chk("orr_fwd_b", fwd_b_sel, 2);

        // Same with XZR destination
        drive(2, 1, 3, 1, 31, 1, 0, 0, 0, 0);
        nop();
        drive(7, 1, 31, 1, 6, 1, 0, 0, 0, 0);
        nop();
        chk("xzr_fwd_b", fwd_b_sel, 0);

        // LDUR X9,[X10] ; ADD X11,X9,X9
        drive(10, 1, 0, 0, 9, 1, 1, 0, 0, 0);
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        chk("lu_stall_pc", stall_pc, 1);
        chk("lu_bubble", bubble_ex, 1);
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        chk("lu_one_cycle", stall_ifrf, 0);
        nop();
        chk("lu_fwd_a", fwd_a_sel, 2);
        chk("lu_fwd_b", fwd_b_sel, 2);

        // ADDS X1,X2,X3 ; B.EQ
        drive(2, 1, 3, 1, 1, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 31, 0, 0, 0, 1, 0);
        chk("flag_fwd_hit", flag_fwd, 1);
        chk("flag_no_stall", stall_pc, 0);
        // ADDS ; bubble ; B.EQ
        drive(2, 1, 3, 1, 1, 1, 0, 1, 0, 0);
        nop();
        drive(0, 0, 0, 0, 31, 0, 0, 0, 1, 0);
        chk("flag_fwd_bubble", flag_fwd, 0);

        // Flush concurrent with load-use
        drive(10, 1, 0, 0, 9, 1, 1, 0, 0, 0);
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 1);
        chk("fl_flush", flush_ifrf, 1);
        chk("fl_bubble", bubble_ex, 1);
        chk("fl_stall", stall_pc, 0);
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        chk("fl_ex_invalid", stall_pc, 0);

        // Reset during a load-use stall
        drive(10, 1, 0, 0, 9, 1, 1, 0, 0, 0);
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        chk("rst_pre_stall", stall_pc, 1);
        reset = 1;
        drive(9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
        reset = 0;
        #1;
        chk("rst_stall", stall_pc, 0);
        chk("rst_bubble", bubble_ex, 0);
        chk("rst_fwd_a", fwd_a_sel, 0);
        nop();
        chk("rst_resume_fwd", fwd_a_sel, 0);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            bit [1:0] mtr;
            mtr = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            drive(pick_reg(), 1'($urandom), pick_reg(), 1'($urandom), pick_reg(),
                  1'($urandom_range(0, 3) != 0), mtr, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1;
                drive(0, 0, 0, 0, 31, 0, 0, 0, 0, 0);
                reset = 0;
            end
        end

        @(negedge clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
